// File: rtl/pc_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_pkg
//   Definitions shared by the fetch unit and its neighbours:
//   - FSM state encoding for the fetch controller (2 bits).
//   - Default reset PC (word address).
//   - Next-PC select codes, so the decoder and the next-PC stage agree on
//     which code means "hold the current PC".
// ----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10,
        S_ERR   = 2'b11
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // NPC_HOLD makes npc == pc, which re-fetches the same word.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_HOLD   = 2'b01,
        NPC_BRANCH = 2'b10,
        NPC_JUMP   = 2'b11
    } npc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_fetch_watchdog.sv
// ----------------------------------------------------------------------------
// fetch_watchdog
//   Counts cycles spent waiting for an instruction-memory acknowledge and
//   flags the cycle in which the wait budget runs out.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     enable   in   a fetch is outstanding and not acknowledged this cycle
//     clear    in   restart the count from zero (takes priority)
//     expired  out  this is the last allowed wait cycle and it is unacknowledged
//
//   ACK_TIMEOUT = 0 disables the watchdog (expired is tied low).
// ----------------------------------------------------------------------------
import pc_fetch_unit_pkg::*;

module fetch_watchdog #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam bit               WD_ON    = (ACK_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] LAST_CNT = WD_ON ? TMO_W'(ACK_TIMEOUT - 1) : '0;
    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};

    logic [TMO_W-1:0] tmo_cnt;

    // Saturating counter: it stops at all-ones instead of wrapping, so a
    // disabled or oversized budget can never alias back to a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (clear) begin
            tmo_cnt <= '0;
        end else if (enable && (tmo_cnt != CNT_MAX)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign expired = WD_ON && enable && (tmo_cnt == LAST_CNT);

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Holds the architectural PC and fetches the instruction word at PC from a
//   word-addressed instruction memory that may insert wait states.
//
//   Ports:
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     npc          in   next PC from the next-PC stage (combinational from pc)
//     pc           out  current PC register
//     imem_req     out  fetch request, held high until imem_ack
//     imem_addr    out  fetch word address (equals pc while imem_req=1)
//     imem_rdata   in   instruction word, valid with imem_ack
//     imem_ack     in   one-cycle response strobe
//     instr        out  captured instruction
//     instr_valid  out  instr holds the word fetched from pc
//     instr_ready  in   decoder consumes instr this cycle
//     fetch_err    out  sticky: acknowledge watchdog expired
//
//   pc only moves on the instr_valid & instr_ready handshake, so the next-PC
//   stage sees a stable pc for the whole fetch. Peak rate is one instruction
//   every two cycles.
// ----------------------------------------------------------------------------
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
);

    fetch_state_t state, state_d;
    logic [31:0]  pc_d, imem_addr_d, instr_d;
    logic         imem_req_d, instr_valid_d, fetch_err_d;
    logic         wd_enable, wd_clear, wd_expired;

    // The counter runs only while a fetch is outstanding and unanswered; it
    // is held at zero everywhere else so every fetch starts a fresh budget.
    assign wd_enable = (state == S_FETCH) && !imem_ack;
    assign wd_clear  = (state != S_FETCH) || imem_ack;

    fetch_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            imem_req    <= imem_req_d;
            imem_addr   <= imem_addr_d;
            instr       <= instr_d;
            instr_valid <= instr_valid_d;
            fetch_err   <= fetch_err_d;
        end
    end

    // All outputs are registered, so this block computes their next values.
    // Acknowledge is checked before the watchdog: a reply on the last allowed
    // cycle is accepted rather than flagged.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        imem_req_d    = imem_req;
        imem_addr_d   = imem_addr;
        instr_d       = instr;
        instr_valid_d = instr_valid;
        fetch_err_d   = fetch_err;

        unique case (state)
            S_BOOT: begin
                // Any ack seen here belongs to a fetch killed by reset.
                state_d     = S_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = S_VALID;
                end else if (wd_expired) begin
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    state_d     = S_ERR;
                end
            end
            S_VALID: begin
                // npc is taken verbatim (no wrap check) and only here.
                if (instr_ready) begin
                    pc_d          = npc;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = npc;
                    state_d       = S_FETCH;
                end
            end
            S_ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16),
        .TMO_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in the first request cycle of a fetch of word a. The memory
    // stalls for 'waits' extra cycles, then acknowledges; the expected word
    // is queued when driven and popped once instr_valid shows up.
    task automatic serve(input logic [31:0] a, input int waits);
        check("req_up", imem_req, 1);
        check("req_addr", imem_addr, a);
        for (int k = 0; k < waits; k++) begin
            step;
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, a);
            check("wait_valid", instr_valid, 0);
            check("wait_err", fetch_err, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(a);
        exp_q.push_back(imem_rdata);
        step;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("valid_after_ack", instr_valid, 1);
        check("req_drop", imem_req, 0);
        check("instr_q_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("instr", instr, exp_q.pop_front());
    endtask

    initial begin
        rst_n       = 1'b0;
        npc         = '0;
        imem_rdata  = '0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        step;
        step;
        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_err", fetch_err, 0);

        // Zero-wait memory, decoder always ready, sequential PC.
        rst_n = 1'b1;
        step;
        check("first_req", imem_req, 1);
        for (int i = 0; i < 4; i++) begin
            instr_ready = 1'b1;
            npc = 32'(i + 1);
            serve(32'(i), 0);
            check("pc_during_valid", pc, 32'(i));
            step;
            check("pc_advance", pc, 32'(i + 1));
        end

        // Five wait states.
        instr_ready = 1'b0;
        npc = 32'h55;
        serve(32'h4, 5);
        check("t2_err", fetch_err, 0);

        // Decoder stalls while npc toggles.
        for (int i = 0; i < 10; i++) begin
            npc = i[0] ? 32'hDEAD_0000 : 32'h0000_1234;
            step;
            check("hold_pc", pc, 32'h4);
            check("hold_instr", instr, mem_word(32'h4));
            check("hold_valid", instr_valid, 1);
            check("hold_req", imem_req, 0);
        end
        instr_ready = 1'b1;
        npc = 32'h40;
        step;
        instr_ready = 1'b0;
        check("redirect_addr", imem_addr, 32'h40);
        check("redirect_pc", pc, 32'h40);
        check("redirect_valid", instr_valid, 0);

        // Ack on the 16th request cycle: accepted, no error.
        serve(32'h40, 15);
        check("t5_err", fetch_err, 0);

        // No ack ever: error after the 16th request cycle.
        instr_ready = 1'b1;
        npc = 32'h80;
        step;
        instr_ready = 1'b0;
        check("t4_addr", imem_addr, 32'h80);
        for (int i = 1; i < 16; i++) begin
            step;
            check("t4_req", imem_req, 1);
            check("t4_no_err_yet", fetch_err, 0);
        end
        step;
        check("t4_err", fetch_err, 1);
        check("t4_req_drop", imem_req, 0);
        check("t4_valid", instr_valid, 0);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        npc         = 32'h99;
        for (int i = 0; i < 4; i++) begin
            step;
            check("stuck_err", fetch_err, 1);
            check("stuck_req", imem_req, 0);
            check("stuck_pc", pc, 32'h80);
            check("stuck_valid", instr_valid, 0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t4_rst_err", fetch_err, 0);
        check("t4_rst_pc", pc, 32'h0);
        step;
        rst_n = 1'b1;
        step;
        check("t4_restart_req", imem_req, 1);
        check("t4_restart_addr", imem_addr, 32'h0);

        // Reset in the middle of a fetch at pc=0x20, stray ack in S_BOOT.
        instr_ready = 1'b1;
        npc = 32'h20;
        serve(32'h0, 0);
        step;
        instr_ready = 1'b0;
        check("t6_addr", imem_addr, 32'h20);
        step;
        step;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", imem_req, 0);
        check("t6_pc", pc, 32'h0);
        check("t6_valid", instr_valid, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step;
        rst_n = 1'b1;
        step;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("t6_stray_valid", instr_valid, 0);
        check("t6_stray_instr", instr, 32'h0);
        check("t6_req", imem_req, 1);
        check("t6_addr_reset", imem_addr, 32'h0);

        // PC at the top of the address space followed by npc=0.
        instr_ready = 1'b1;
        npc = 32'hFFFF_FFFF;
        serve(32'h0, 0);
        step;
        check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFF);
        npc = 32'h0;
        serve(32'hFFFF_FFFF, 0);
        step;
        check("wrap_addr_lo", imem_addr, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
